fnd_tick_gen: RTL and testbench

FND_TICK_GEN -- requirements
Module: fnd_tick_gen

---
 rtl/fnd_clk_pkg.sv | 15 +
 rtl/fnd_div_ch.sv | 88 ++++++++
 rtl/fnd_tick_gen.sv | 73 +++++++
 tb/tb_fnd_tick_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_clk_pkg.sv
// Shared constants and helpers for the FND scan-clock divider.
// Defaults target a 1 kHz digit scan from a 100 MHz system clock.
package fnd_clk_pkg;

    localparam int CNT_W_DEF    = 32;
    localparam int DIV_INIT_DEF = 50_000;
    localparam int NUM_CH_DEF   = 2;
    localparam int NUM_CH_MAX   = 8;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fnd_div_ch.sv
// One divider channel: counter, active/shadow divisor and output toggle.
// New divisors take effect only at a terminal count (or on sync) so no half-period is truncated.
module fnd_div_ch #(
    parameter int CNT_W    = 32,
    parameter int DIV_INIT = 50_000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_sync,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             term;

    always_comb begin
        // >= keeps the channel from running past a freshly lowered divisor
        term     = i_en && (cnt_q >= (div_q - ONE));
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        pend_d   = pend_q;

        if (i_load) begin
            shadow_d = i_div;
            pend_d   = 1'b1;
        end

        if (i_sync) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            pend_d = 1'b0;
            if (i_load) begin
                div_d = i_div;
            end else if (pend_q) begin
                div_d = shadow_q;
            end
        end else if (term) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
            if (pend_q) begin
                div_d  = shadow_q;
                pend_d = i_load;
            end
        end else if (i_en) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q    <= '0;
            div_q    <= DIV_RST;
            shadow_q <= DIV_RST;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_tick = tick_q;
    assign o_pend = pend_q;

endmodule

// File: rtl/fnd_tick_gen.sv
// Multi-channel 50%-duty divided clock and tick generator for FND digit scanning.
// Define FND_TICK_GEN_SYNC_EN to enable the i_sync phase-alignment strobe.
module fnd_tick_gen
    import fnd_clk_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_en,
    input  logic                         i_load,
    input  logic [sel_width(NUM_CH)-1:0] i_ch_sel,
    input  logic [CNT_W-1:0]             i_div,
    input  logic                         i_sync,
    output logic [NUM_CH-1:0]            o_clk,
    output logic [NUM_CH-1:0]            o_tick,
    output logic [NUM_CH-1:0]            o_pend,
    output logic                         o_err
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic sel_ok;
    logic div_ok;
    logic load_ok;
    logic err_q, err_d;
    logic sync_w;

`ifdef FND_TICK_GEN_SYNC_EN
    assign sync_w = i_sync;
`else
    logic unused_sync;
    assign unused_sync = i_sync;
    assign sync_w      = 1'b0;
`endif

    always_comb begin
        sel_ok  = (int'(i_ch_sel) < NUM_CH);
        div_ok  = (i_div != '0);
        load_ok = i_load && sel_ok && div_ok;
        err_d   = i_load && !(sel_ok && div_ok);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fnd_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_en      (i_en),
            .i_load    (load_ok && (i_ch_sel == SEL_W'(g))),
            .i_sync    (sync_w),
            .i_div     (i_div),
            .o_clk     (o_clk[g]),
            .o_tick    (o_tick[g]),
            .o_pend    (o_pend[g])
        );
    end

endmodule

// File: tb/tb_fnd_tick_gen.sv
// Self-checking bench for fnd_tick_gen: directed scenarios plus random traffic
// compared every cycle against a countdown-style reference model.
module tb_fnd_tick_gen;

    localparam int NCH  = 3;
    localparam int CW   = 16;
    localparam int DINIT = 4;

    logic            i_clk;
    logic            i_reset_n;
    logic            i_en;
    logic            i_load;
    logic [1:0]      i_ch_sel;
    logic [CW-1:0]   i_div;
    logic            i_sync;
    logic [NCH-1:0]  o_clk;
    logic [NCH-1:0]  o_tick;
    logic [NCH-1:0]  o_pend;
    logic            o_err;

    fnd_tick_gen #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV_INIT (DINIT)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .i_load    (i_load),
        .i_ch_sel  (i_ch_sel),
        .i_div     (i_div),
        .i_sync    (i_sync),
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_pend    (o_pend),
        .o_err     (o_err)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: cycles remaining until the next toggle per channel
    int       m_div[NCH];
    int       m_shadow[NCH];
    int       m_remain[NCH];
    bit [NCH-1:0] m_clk;
    bit [NCH-1:0] m_tick;
    bit [NCH-1:0] m_pend;
    bit       m_err;

    logic [3*NCH:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]    = DINIT;
            m_shadow[c] = DINIT;
            m_remain[c] = DINIT;
        end
        m_clk  = '0;
        m_tick = '0;
        m_pend = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit ld, input int sel, input int dv, input bit sy);
        bit bad;
        bit sync_eff;
        bit hit;
        bad = ld && (dv == 0 || sel >= NCH);
`ifdef FND_TICK_GEN_SYNC_EN
        sync_eff = sy;
`else
        sync_eff = 1'b0;
`endif
        m_err = bad;
        for (int c = 0; c < NCH; c++) begin
            hit       = ld && !bad && (sel == c);
            m_tick[c] = 1'b0;
            if (sync_eff) begin
                if (hit) begin
                    m_div[c]    = dv;
                    m_shadow[c] = dv;
                end else if (m_pend[c]) begin
                    m_div[c] = m_shadow[c];
                end
                m_pend[c]   = 1'b0;
                m_clk[c]    = 1'b0;
                m_remain[c] = m_div[c];
            end else begin
                if (en) begin
                    m_remain[c]--;
                    if (m_remain[c] == 0) begin
                        m_clk[c]  = ~m_clk[c];
                        m_tick[c] = 1'b1;
                        if (m_pend[c]) begin
                            m_div[c]  = m_shadow[c];
                            m_pend[c] = 1'b0;
                        end
                        m_remain[c] = m_div[c];
                    end
                end
                if (hit) begin
                    m_shadow[c] = dv;
                    m_pend[c]   = 1'b1;
                end
            end
        end
    endtask

    // driver: apply one cycle of inputs, advance model, compare outputs
    task automatic step(input bit en, input bit ld, input int sel, input int dv, input bit sy);
        logic [3*NCH:0] e;
        i_en     = en;
        i_load   = ld;
        i_ch_sel = 2'(sel);
        i_div    = CW'(dv);
        i_sync   = sy;
        @(posedge i_clk);
        model_step(en, ld, sel, dv, sy);
        exp_q.push_back({m_clk, m_tick, m_pend, m_err});
        #1;
        e = exp_q.pop_front();
        check("o_clk",  32'(o_clk),  32'(e[3*NCH -: NCH]));
        check("o_tick", 32'(o_tick), 32'(e[2*NCH -: NCH]));
        check("o_pend", 32'(o_pend), 32'(e[NCH:1]));
        check("o_err",  32'(o_err),  32'(e[0]));
    endtask

    // asynchronous reset pulse away from any clock edge
    task automatic do_reset();
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        check("rst_clk",  32'(o_clk),  32'(m_clk));
        check("rst_tick", 32'(o_tick), 32'(m_tick));
        check("rst_pend", 32'(o_pend), 32'(m_pend));
        check("rst_err",  32'(o_err),  32'(m_err));
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n = 1'b1;
        i_en      = 1'b0;
        i_load    = 1'b0;
        i_ch_sel  = '0;
        i_div     = '0;
        i_sync    = 1'b0;
        @(negedge i_clk);
        do_reset();

        // free run from reset: toggles and ticks on cycles 4, 8, 12
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step(1, 0, 0, 0, 0);
            check("run_tick0", 32'(o_tick[0]), 32'((cyc % 4) == 0));
            check("run_clk0",  32'(o_clk[0]),  32'((cyc / 4) % 2));
        end

        // load ch1 div=3 at cnt=1: pending until terminal, then 6-cycle period
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 3, 0);
        for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 0);

        // rejected loads: zero divisor and out-of-range channel
        step(1, 1, 0, 0, 0);
        check("err_div0", 32'(o_err), 32'd1);
        step(1, 1, 3, 5, 0);
        check("err_sel",  32'(o_err), 32'd1);
        step(1, 0, 0, 0, 0);
        check("err_gone", 32'(o_err), 32'd0);

        // enable held low for 10 cycles with a pending shadow
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 2, 2, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) step(1, 0, 0, 0, 0);

        // sync coincident with terminal count and a load of 7
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 7, 1);
        for (int k = 0; k < 16; k++) step(1, 0, 0, 0, 0);

        // async reset mid-period discards a pending load
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 2, 0);
        step(1, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            int dv;
            dv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            step($urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 20,
                 int'($urandom_range(0, 3)),
                 dv,
                 $urandom_range(0, 99) < 5);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
